// File: rtl/str_cla_16adder_pkg.sv
// Shared types for the 16-bit registered carry-lookahead adder.
// Only the flag bundle lives here; the data width stays local to the top.
package str_cla_16adder_pkg;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic parity;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/str_cla_16adder_cla_4bit.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate
// for the second-level lookahead in the top.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       G,
  output logic       P
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] cy;

  assign g = a & b;
  assign p = a ^ b;

  assign cy[0] = cin;
  assign cy[1] = g[0] | (p[0] & cin);
  assign cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ cy;

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

endmodule

// File: rtl/str_cla_16adder.sv
// 16-bit two-level carry-lookahead adder with registered sum and
// sign/zero/carry/parity/overflow flags; one result per clock, 1-cycle latency.
module str_cla_16adder
  import str_cla_16adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c,
  output logic        sign,
  output logic        zero,
  output logic        carry,
  output logic        parity,
  output logic        overflow
);

  localparam int WIDTH  = 16;
  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0]  sum_d;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS:0]   grp_c;
  flags_t            flags_d;
  logic [WIDTH-1:0]  c_q;
  flags_t            flags_q;

  for (genvar k = 0; k < GROUPS; k++) begin : g_grp
    cla_4bit u_cla (
      .a   (a[4*k +: 4]),
      .b   (b[4*k +: 4]),
      .cin (grp_c[k]),
      .s   (sum_d[4*k +: 4]),
      .G   (grp_g[k]),
      .P   (grp_p[k])
    );
  end

  // Second-level lookahead: every group carry comes straight from G/P.
  assign grp_c[0] = 1'b0;
  assign grp_c[1] = grp_g[0];
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                  | (grp_p[2] & grp_p[1] & grp_g[0]);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                  | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

  assign flags_d.sign     = sum_d[WIDTH-1];
  assign flags_d.zero     = ~|sum_d;
  assign flags_d.carry    = grp_c[GROUPS];
  assign flags_d.parity   = ~^sum_d;
  assign flags_d.overflow = (a[WIDTH-1] & b[WIDTH-1] & ~sum_d[WIDTH-1])
                          | (~a[WIDTH-1] & ~b[WIDTH-1] & sum_d[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      c_q     <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign c        = c_q;
  assign sign     = flags_q.sign;
  assign zero     = flags_q.zero;
  assign carry    = flags_q.carry;
  assign parity   = flags_q.parity;
  assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_str_cla_16adder.sv
// Self-checking bench for str_cla_16adder: directed corner vectors, random
// traffic and asynchronous reset, against an arithmetic reference model.
module tb_str_cla_16adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic        sign;
  logic        zero;
  logic        carry;
  logic        parity;
  logic        overflow;

  int n_total;
  int n_pass;

  str_cla_16adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .sign     (sign),
    .zero     (zero),
    .carry    (carry),
    .parity   (parity),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {c, sign, zero, carry, parity, overflow}.
  function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y);
    int unsigned usum;
    int          ssum;
    logic [15:0] s;
    logic        cy, ov, par;
    usum = int'(x) + int'(y);
    s    = 16'(usum % 65536);
    cy   = (usum >= 65536);
    ssum = int'($signed(x)) + int'($signed(y));
    ov   = (ssum > 32767) || (ssum < -32768);
    par  = ($countones(s) % 2) == 0;
    return {s, s[15], s == 16'h0000, cy, par, ov};
  endfunction

  function automatic logic [20:0] observed();
    return {c, sign, zero, carry, parity, overflow};
  endfunction

  task automatic test_reset();
    a = 16'h1234; b = 16'h4321; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (observed() !== 21'h0) $display("FAIL reset_state got=%h exp=%h", observed(), 21'h0);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h8fff, 16'h6ffe, 16'haaaa, 16'hffff, 16'h0000};
    logic [15:0] vb [5] = '{16'h8000, 16'h0002, 16'h5555, 16'h0001, 16'h0000};
    logic [20:0] ve [5] = '{{16'h0fff, 5'b00111}, {16'h7000, 5'b00000},
                            {16'hffff, 5'b10010}, {16'h0000, 5'b01110},
                            {16'h0000, 5'b01010}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) begin a = va[i]; b = vb[i]; end
      @(posedge clk); #1;
      n_total++;
      if (observed() !== ve[i])
        $display("FAIL directed_%0d a=%h b=%h got=%h exp=%h", i, va[i], vb[i], observed(), ve[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [20:0] exp;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk) begin a = 16'($urandom); b = 16'($urandom); end
      exp = model(a, b);
      @(posedge clk); #1;
      n_total++;
      if (observed() !== exp)
        $display("FAIL random_%0d a=%h b=%h got=%h exp=%h", i, a, b, observed(), exp);
      else n_pass++;
    end
  endtask

  // New operands each cycle; also confirm outputs hold while inputs move mid-cycle.
  task automatic test_back_to_back();
    logic [20:0] exp;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk) begin a = 16'($urandom); b = 16'($urandom); end
      exp = model(a, b);
      @(posedge clk); #1;
      n_total++;
      if (observed() !== exp)
        $display("FAIL b2b_%0d got=%h exp=%h", i, observed(), exp);
      else n_pass++;
      a = ~a; b = b + 16'h1357;
      #2;
      n_total++;
      if (observed() !== exp)
        $display("FAIL hold_%0d got=%h exp=%h", i, observed(), exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [20:0] exp;
    @(negedge clk) begin a = 16'h8fff; b = 16'h8000; end
    exp = model(a, b);
    @(posedge clk); #1;
    n_total++;
    if (observed() !== exp) $display("FAIL pre_reset got=%h exp=%h", observed(), exp);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (observed() !== 21'h0) $display("FAIL async_reset got=%h exp=%h", observed(), 21'h0);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (observed() !== 21'h0) $display("FAIL reset_hold got=%h exp=%h", observed(), 21'h0);
    else n_pass++;
    @(negedge clk) begin rst_n = 1'b1; a = 16'haaaa; b = 16'h5555; end
    #1;
    n_total++;
    if (observed() !== 21'h0) $display("FAIL post_release got=%h exp=%h", observed(), 21'h0);
    else n_pass++;
    exp = model(a, b);
    @(posedge clk); #1;
    n_total++;
    if (observed() !== exp) $display("FAIL first_after_reset got=%h exp=%h", observed(), exp);
    else n_pass++;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    a       = '0;
    b       = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/str_cla_16adder.md
STR_CLA_16ADDER -- requirements
Module: str_cla_16adder

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all output registers.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a  input  16  first addend, unsigned or two's complement.
REQ-006 b  input  16  second addend, unsigned or two's complement.
REQ-007 c  output  16  registered sum a+b mod 2^16.
REQ-008 sign  output  1  registered c[15].
REQ-009 zero  output  1  registered; 1 when sum == 16'h0000.
REQ-010 carry  output  1  registered carry-out of bit 15.
REQ-011 parity  output  1  registered even-parity flag: 1 when the sum has an even number of 1 bits (XNOR-reduction of the sum).
REQ-012 overflow  output  1  registered signed overflow: (a[15]&b[15]&~s[15]) | (~a[15]&~b[15]&s[15]), where s is the sum.

Function
REQ-013 The sum and carry-out SHALL be computed combinationally by a carry-lookahead network: per-bit generate g=a&b and propagate p=a^b; sum bit = p ^ carry-in.
REQ-014 The adder SHALL be organised as four 4-bit CLA groups, each producing group generate G and propagate P.
REQ-015 A second-level lookahead unit SHALL derive group carry-ins c4, c8, c12 and carry-out c16 from G/P with carry-in 0; no ripple between groups.
REQ-016 There SHALL be no external carry-in; bit-0 carry-in is constant 0.
REQ-017 All flags SHALL be derived from the same combinational sum and carry as c, in the same cycle.
REQ-018 On every rising clk edge with rst_n high, c and all five flags SHALL load the result for the a/b present at that edge; latency is exactly 1 cycle; there is no enable and no handshake.
REQ-019 Throughput SHALL be one addition per cycle; back-to-back input changes produce back-to-back results.
REQ-020 Wrap-around: sums >= 2^16 SHALL be truncated to 16 bits, with carry=1.
REQ-021 carry and overflow are independent; both, either or neither SHALL be settable by one operation.

Reset
REQ-022 While rst_n is low, c SHALL be 16'h0000 and sign, zero, carry, parity and overflow SHALL all be 0, regardless of clk.
REQ-023 Reset assertion SHALL take effect immediately (asynchronously), including mid-operation; the pending result is discarded.
REQ-024 After rst_n deasserts, the first rising clk edge SHALL load a valid result.

Structure
REQ-025 A single sub-module cla_4bit SHALL implement the 4-bit group (inputs a[3:0], b[3:0], cin; outputs s[3:0], G, P) and be instantiated four times.
REQ-026 The second-level carry logic and the flag logic SHALL be written in the top module as explicit gate-level equations.
REQ-027 No shared package is required; the width constant 16 stays local.

Verification
REQ-028 Each result SHALL be checked one cycle after the inputs are applied, with rst_n high. The parity values below follow REQ-011.
REQ-029 a=8fff, b=8000 -> c=0fff, sign=0, zero=0, carry=1, parity=1, overflow=1.
REQ-030 a=6ffe, b=0002 -> c=7000, sign=0, zero=0, carry=0, parity=0, overflow=0.
REQ-031 a=aaaa, b=5555 -> c=ffff, sign=1, zero=0, carry=0, parity=1, overflow=0. This exercises full-length propagate.
REQ-032 a=ffff, b=0001 -> c=0000, sign=0, zero=1, carry=1, parity=1, overflow=0.
REQ-033 a=0000, b=0000 -> c=0000, zero=1, parity=1, other flags 0.
REQ-034 Assert rst_n low between clock edges after a nonzero result -> all outputs 0 immediately; they stay 0 until the first edge after release.
